// File: rtl/alu_ctrl_decode_pipe.sv
// alu_ctrl_decode_pipe: registered MIPS ALU control decoder.
// Decodes R-type (and optionally I-type) ALU instructions into register-file
// and ALU controls, held in a one-entry output stage with valid/ready
// backpressure, flush, illegal flagging and a saturating illegal counter.
module alu_ctrl_decode_pipe #(
   parameter int ALU_OP_W       = 3,
   parameter int ENABLE_ITYPE   = 1,
   parameter int ZERO_REG_GUARD = 1,
   parameter int CNT_W          = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                we,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [4:0]          rs,
   output logic [4:0]          rt,
   output logic [4:0]          rd_dst,
   output logic [31:0]         imm_ext,
   output logic                use_imm,
   output logic                illegal,
   output logic [CNT_W-1:0]    illegal_count
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t                state_r, state_nxt_s;
   logic                  accept_s, in_ready_s;

   // decoded fields before the output register
   logic [5:0]            op_s, func_s;
   logic [2:0]            code_s;
   logic                  rtype_ok_s, itype_ok_s, sext_s, legal_s;
   logic                  we_s, use_imm_s;
   logic [4:0]            dst_s;
   logic [31:0]           imm_s;

   // output stage registers
   logic                  we_r, use_imm_r, illegal_r;
   logic [ALU_OP_W-1:0]   alu_op_r;
   logic [4:0]            rs_r, rt_r, rd_dst_r;
   logic [31:0]           imm_ext_r;
   logic [CNT_W-1:0]      illegal_count_r;

   assign op_s   = instr[31:26];
   assign func_s = instr[5:0];

   // Output-stage state register; reset drops any held instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= EMPTY;
      else        state_r <= state_nxt_s;
   end

   // Output-stage next state; flush wins over accept and the held entry.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         EMPTY: begin
            if (flush)         state_nxt_s = EMPTY;
            else if (accept_s) state_nxt_s = FULL;
            else               state_nxt_s = EMPTY;
         end
         FULL: begin
            if (flush)          state_nxt_s = EMPTY;
            else if (accept_s)  state_nxt_s = FULL;
            else if (out_ready) state_nxt_s = EMPTY;
            else                state_nxt_s = FULL;
         end
         default: state_nxt_s = EMPTY;
      endcase
   end

   // Handshake outputs; a flush blocks the incoming word.
   always_comb begin
      in_ready_s = (state_r == EMPTY || out_ready) && !flush;
      accept_s   = in_valid && in_ready_s;
   end

   // Opcode/func decode into a 3-bit ALU code and legality flags.
   always_comb begin
      code_s     = 3'b000;
      rtype_ok_s = 1'b0;
      itype_ok_s = 1'b0;
      sext_s     = 1'b0;
      case (op_s)
         6'b000000: begin
            rtype_ok_s = 1'b1;
            case (func_s)
               6'b100000: code_s = 3'b100;
               6'b100010: code_s = 3'b101;
               6'b100100: code_s = 3'b000;
               6'b100101: code_s = 3'b001;
               6'b100110: code_s = 3'b010;
               6'b100111: code_s = 3'b011;
               6'b101011: code_s = 3'b110;
               6'b000100: code_s = 3'b111;
               default:   rtype_ok_s = 1'b0;
            endcase
         end
         6'b001000: begin itype_ok_s = 1'b1; code_s = 3'b100; sext_s = 1'b1; end
         6'b001011: begin itype_ok_s = 1'b1; code_s = 3'b110; sext_s = 1'b1; end
         6'b001100: begin itype_ok_s = 1'b1; code_s = 3'b000; end
         6'b001101: begin itype_ok_s = 1'b1; code_s = 3'b001; end
         6'b001110: begin itype_ok_s = 1'b1; code_s = 3'b010; end
         default:   code_s = 3'b000;
      endcase
   end

   // Field assembly: illegal words zero everything except rs/rt.
   always_comb begin
      legal_s   = rtype_ok_s || (itype_ok_s && (ENABLE_ITYPE != 0));
      dst_s     = 5'd0;
      imm_s     = 32'h0000_0000;
      use_imm_s = 1'b0;
      we_s      = 1'b0;
      if (!legal_s) begin
         dst_s = 5'd0;
      end else if (rtype_ok_s) begin
         dst_s = instr[15:11];
      end else begin
         dst_s     = instr[20:16];
         use_imm_s = 1'b1;
         if (sext_s) imm_s = {{16{instr[15]}}, instr[15:0]};
         else        imm_s = {16'h0000, instr[15:0]};
      end
      if (legal_s && !((ZERO_REG_GUARD != 0) && (dst_s == 5'd0))) we_s = 1'b1;
      else                                                        we_s = 1'b0;
   end

   // Output register: loads on accept, otherwise holds for backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r      <= 1'b0;
         alu_op_r  <= '0;
         rs_r      <= 5'd0;
         rt_r      <= 5'd0;
         rd_dst_r  <= 5'd0;
         imm_ext_r <= 32'h0000_0000;
         use_imm_r <= 1'b0;
         illegal_r <= 1'b0;
      end else if (accept_s) begin
         we_r      <= we_s;
         alu_op_r  <= legal_s ? ALU_OP_W'(code_s) : '0;
         rs_r      <= instr[25:21];
         rt_r      <= instr[20:16];
         rd_dst_r  <= dst_s;
         imm_ext_r <= imm_s;
         use_imm_r <= use_imm_s;
         illegal_r <= !legal_s;
      end
   end

   // Saturating count of accepted illegal words; flushed words never count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal_count_r <= '0;
      else if (accept_s && !legal_s && (illegal_count_r != CNT_MAX))
         illegal_count_r <= illegal_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign in_ready      = in_ready_s;
   assign out_valid     = (state_r == FULL);
   assign we            = we_r;
   assign alu_op        = alu_op_r;
   assign rs            = rs_r;
   assign rt            = rt_r;
   assign rd_dst        = rd_dst_r;
   assign imm_ext       = imm_ext_r;
   assign use_imm       = use_imm_r;
   assign illegal       = illegal_r;
   assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_alu_ctrl_decode_pipe.sv
// Directed testbench for alu_ctrl_decode_pipe: default instance plus a
// CNT_W=2 instance and an ENABLE_ITYPE=0 instance sharing the same stimulus.
module tb_alu_ctrl_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic [31:0] instr;

   logic        in_ready_m, out_valid_m, we_m, use_imm_m, illegal_m;
   logic [2:0]  alu_op_m;
   logic [4:0]  rs_m, rt_m, rd_m;
   logic [31:0] imm_m;
   logic [7:0]  cnt_m;

   logic        in_ready_c, out_valid_c, we_c, use_imm_c, illegal_c;
   logic [2:0]  alu_op_c;
   logic [4:0]  rs_c, rt_c, rd_c;
   logic [31:0] imm_c;
   logic [1:0]  cnt_c;

   logic        in_ready_n, out_valid_n, we_n, use_imm_n, illegal_n;
   logic [2:0]  alu_op_n;
   logic [4:0]  rs_n, rt_n, rd_n;
   logic [31:0] imm_n;
   logic [7:0]  cnt_n;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_ctrl_decode_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
      .instr(instr), .flush(flush), .out_valid(out_valid_m), .out_ready(out_ready),
      .we(we_m), .alu_op(alu_op_m), .rs(rs_m), .rt(rt_m), .rd_dst(rd_m),
      .imm_ext(imm_m), .use_imm(use_imm_m), .illegal(illegal_m), .illegal_count(cnt_m));

   alu_ctrl_decode_pipe #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
      .instr(instr), .flush(flush), .out_valid(out_valid_c), .out_ready(out_ready),
      .we(we_c), .alu_op(alu_op_c), .rs(rs_c), .rt(rt_c), .rd_dst(rd_c),
      .imm_ext(imm_c), .use_imm(use_imm_c), .illegal(illegal_c), .illegal_count(cnt_c));

   alu_ctrl_decode_pipe #(.ENABLE_ITYPE(0)) dut_ni (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
      .instr(instr), .flush(flush), .out_valid(out_valid_n), .out_ready(out_ready),
      .we(we_n), .alu_op(alu_op_n), .rs(rs_n), .rt(rt_n), .rd_dst(rd_n),
      .imm_ext(imm_n), .use_imm(use_imm_n), .illegal(illegal_n), .illegal_count(cnt_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 32'h0;
      #3;
      chk("rst_out_valid", 32'(out_valid_m), 32'd0);
      chk("rst_we",        32'(we_m),        32'd0);
      chk("rst_alu_op",    32'(alu_op_m),    32'd0);
      chk("rst_illegal",   32'(illegal_m),   32'd0);
      chk("rst_count",     32'(cnt_m),       32'd0);
      chk("rst_imm",       imm_m,            32'd0);
      #9 rst_n = 1'b1;
      tick();
      chk("in_ready_idle", 32'(in_ready_m), 32'd1);

      // add $8,$9,$10
      instr = 32'h012A4020; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("add_valid",   32'(out_valid_m), 32'd1);
      chk("add_we",      32'(we_m),        32'd1);
      chk("add_op",      32'(alu_op_m),    32'd4);
      chk("add_rs",      32'(rs_m),        32'd9);
      chk("add_rt",      32'(rt_m),        32'd10);
      chk("add_rd",      32'(rd_m),        32'd8);
      chk("add_useimm",  32'(use_imm_m),   32'd0);
      chk("add_imm",     imm_m,            32'd0);

      // addi $5,$0,-1
      instr = 32'h2005FFFF;
      tick();
      chk("addi_imm",    imm_m,            32'hFFFF_FFFF);
      chk("addi_useimm", 32'(use_imm_m),   32'd1);
      chk("addi_rd",     32'(rd_m),        32'd5);
      chk("addi_op",     32'(alu_op_m),    32'd4);
      chk("addi_we",     32'(we_m),        32'd1);
      chk("ni_addi_ill", 32'(illegal_n),   32'd1);
      chk("ni_addi_we",  32'(we_n),        32'd0);
      chk("ni_addi_imm", imm_n,            32'd0);

      // ori $5,$0,0xFFFF
      instr = 32'h3405FFFF;
      tick();
      chk("ori_imm",     imm_m,            32'h0000_FFFF);
      chk("ori_op",      32'(alu_op_m),    32'd1);

      // sltiu $5,$0,-1 (sign-extended)
      instr = 32'h2C05FFFF;
      tick();
      chk("sltiu_imm",   imm_m,            32'hFFFF_FFFF);
      chk("sltiu_op",    32'(alu_op_m),    32'd6);

      // sllv $8,$10,$9
      instr = 32'h012A4004;
      tick();
      chk("sllv_op",     32'(alu_op_m),    32'd7);
      chk("sllv_ill",    32'(illegal_m),   32'd0);

      // drain, then backpressure with two back-to-back words
      in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid_m), 32'd0);
      out_ready = 1'b0; in_valid = 1'b1; instr = 32'h012A4022;   // sub
      #1 chk("bp_rdy_a",  32'(in_ready_m), 32'd1);
      tick();
      chk("bp_a_op",      32'(alu_op_m),    32'd5);
      instr = 32'h012A4024;                                      // and
      #1 chk("bp_rdy_blk", 32'(in_ready_m), 32'd0);
      tick();
      chk("bp_hold_op",   32'(alu_op_m),    32'd5);
      chk("bp_hold_vld",  32'(out_valid_m), 32'd1);
      tick();
      chk("bp_hold_op2",  32'(alu_op_m),    32'd5);
      out_ready = 1'b1;
      #1 chk("bp_rdy_rel", 32'(in_ready_m), 32'd1);
      tick();
      chk("bp_b_op",      32'(alu_op_m),    32'd0);
      chk("bp_b_vld",     32'(out_valid_m), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("bp_nodup",     32'(out_valid_m), 32'd0);

      // illegal R-type func and illegal opcode
      in_valid = 1'b1; instr = 32'h012A4000;
      tick();
      chk("ill_r_flag",   32'(illegal_m),   32'd1);
      chk("ill_r_we",     32'(we_m),        32'd0);
      chk("ill_r_op",     32'(alu_op_m),    32'd0);
      chk("ill_r_rd",     32'(rd_m),        32'd0);
      chk("ill_r_rs",     32'(rs_m),        32'd9);
      chk("ill_r_rt",     32'(rt_m),        32'd10);
      instr = 32'h08000000;
      tick();
      chk("ill_op_flag",  32'(illegal_m),   32'd1);
      chk("ill_cnt2",     32'(cnt_m),       32'd2);
      chk("ill_cnt2_c2",  32'(cnt_c),       32'd2);
      chk("ill_cnt_ni",   32'(cnt_n),       32'd5);
      for (int i = 0; i < 4; i++) tick();
      chk("sat_c2",       32'(cnt_c),       32'd3);
      chk("cnt_main6",    32'(cnt_m),       32'd6);

      // zero-register guard
      instr = 32'h00220020;
      tick();
      chk("zg_we",        32'(we_m),        32'd0);
      chk("zg_ill",       32'(illegal_m),   32'd0);
      chk("zg_op",        32'(alu_op_m),    32'd4);
      chk("zg_rs",        32'(rs_m),        32'd1);
      chk("zg_rt",        32'(rt_m),        32'd2);

      // flush while FULL with an illegal word offered
      out_ready = 1'b0; instr = 32'h08000000; flush = 1'b1;
      #1 chk("fl_rdy",    32'(in_ready_m),  32'd0);
      tick();
      chk("fl_valid",     32'(out_valid_m), 32'd0);
      chk("fl_cnt",       32'(cnt_m),       32'd6);
      flush = 1'b0;

      // async reset in the middle of a stall
      instr = 32'h012A4020;
      tick();
      chk("st_valid",     32'(out_valid_m), 32'd1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid",     32'(out_valid_m), 32'd0);
      chk("ar_we",        32'(we_m),        32'd0);
      chk("ar_op",        32'(alu_op_m),    32'd0);
      chk("ar_rd",        32'(rd_m),        32'd0);
      chk("ar_cnt",       32'(cnt_m),       32'd0);
      in_valid = 1'b0;
      #3 rst_n = 1'b1;
      tick();
      chk("post_rst_vld", 32'(out_valid_m), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
